// File: rtl/sm4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_pkg : shared widths, load-FSM state type and byte-swap helper     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sm4_pkg;

  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic {LD_IDLE, LD_SHIFT} sm4_ld_state_t;

  // Byte 0 of the bus ([7:0]) maps to internal [127:120].
  function automatic logic [127:0] bswap128(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = d[8*(15-i) +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_sipo_cap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_sipo_cap : serial result capture, holding register, overflow flag |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sm4_sipo_cap #(
  parameter int BLK_W = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic             ser_out,
  input  logic             out_ready,
  output logic             ul_ready,
  output logic [BLK_W-1:0] out_blk,
  output logic             out_valid,
  output logic             ovf
);

  logic [BLK_W-2:0] cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [BLK_W-1:0] w_full;
  logic             w_ul_ready;

  assign w_ul_ready = !valid_q | out_ready;
  assign w_full     = {cap_q, ser_out};

  always_comb begin
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (done) begin
      cap_d = w_full[BLK_W-2:0];
      if (!w_ul_ready && cnt_q == '0) begin
        ovf_d = 1'b1;
      end
      // Last bit: refill (possibly in the same cycle as a drain) or drop.
      if (cnt_q == CNT_W'(BLK_W-1)) begin
        cnt_d = '0;
        if (w_ul_ready) begin
          hold_d  = w_full;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ul_ready  = w_ul_ready;
  assign out_blk   = hold_q;
  assign out_valid = valid_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: rtl/sm4_serial_io.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_serial_io : block <-> bit-serial bridge for the SM4 datapath      |
// | SM4_IO_BYTESWAP_EN: byte-reverse in_data/out_data at the port         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sm4_serial_io #(
  parameter int BLK_W = sm4_pkg::BLK_W,
  parameter int CNT_W = sm4_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_act,
  output logic             ld_done,
  output logic             ser_in,
  input  logic             ser_out,
  input  logic             done,
  output logic             ul_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);
  import sm4_pkg::*;

  localparam logic [0:0] ST_IDLE  = 1'(LD_IDLE);
  localparam logic [0:0] ST_SHIFT = 1'(LD_SHIFT);

  logic [BLK_W-1:0] in_blk;
  logic [BLK_W-1:0] out_blk;

`ifdef SM4_IO_BYTESWAP_EN
  assign in_blk   = bswap128(in_data);
  assign out_data = bswap128(out_blk);
`else
  assign in_blk   = in_data;
  assign out_data = out_blk;
`endif

  logic [0:0]       state_q, state_d;
  logic [BLK_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             ld_done_q, ld_done_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ld_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_ready_q && in_valid) begin
          shreg_d = in_blk;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        shreg_d = {shreg_q[BLK_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(BLK_W-1)) begin
          state_d   = ST_IDLE;
          ld_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    // Registered so in_ready stays low through the reset cycle.
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      ld_done_q  <= ld_done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign ld_act   = (state_q == ST_SHIFT);
  assign ld_done  = ld_done_q;
  assign ser_in   = ld_act & shreg_q[BLK_W-1];

  sm4_sipo_cap #(
    .BLK_W (BLK_W),
    .CNT_W (CNT_W)
  ) u_cap (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .ser_out   (ser_out),
    .out_ready (out_ready),
    .ul_ready  (ul_ready),
    .out_blk   (out_blk),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

endmodule
`default_nettype wire
